// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - pattern encodings, default 640x480@60 timing and colour constants
package vga_pkg;

   typedef enum logic [2:0] {
      PAT_WHITE   = 3'd0,
      PAT_RED     = 3'd1,
      PAT_GREEN   = 3'd2,
      PAT_BLUE    = 3'd3,
      PAT_BARS    = 3'd4,
      PAT_CHECKER = 3'd5,
      PAT_BLACK   = 3'd6
   } pat_e;

   localparam int DEF_H_ACTIVE           = 640;
   localparam int DEF_H_FP               = 16;
   localparam int DEF_H_SYNC             = 96;
   localparam int DEF_H_BP               = 48;
   localparam int DEF_V_ACTIVE           = 480;
   localparam int DEF_V_FP               = 10;
   localparam int DEF_V_SYNC             = 2;
   localparam int DEF_V_BP               = 33;
   localparam int DEF_FRAMES_PER_PATTERN = 60;

   // colour triples are ordered {r, g, b}
   localparam logic [2:0] COL_WHITE = 3'b111;
   localparam logic [2:0] COL_RED   = 3'b100;
   localparam logic [2:0] COL_GREEN = 3'b010;
   localparam logic [2:0] COL_BLUE  = 3'b001;
   localparam logic [2:0] COL_BLACK = 3'b000;

   function automatic pat_e next_pattern(input pat_e cur);
      case (cur)
         PAT_WHITE:   return PAT_RED;
         PAT_RED:     return PAT_GREEN;
         PAT_GREEN:   return PAT_BLUE;
         PAT_BLUE:    return PAT_BARS;
         PAT_BARS:    return PAT_CHECKER;
         PAT_CHECKER: return PAT_BLACK;
         default:     return PAT_WHITE;
      endcase
   endfunction

   // bar 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_colour(input logic [2:0] idx);
      return {~idx[1], ~idx[2], ~idx[0]};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters with unregistered sync/enable decode, bar index and frame-end strobe
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync_c,
   output logic       vsync_c,
   output logic       de_c,
   output logic       frame_end,
   output logic [2:0] bar_idx,
   output logic       checker_on
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [BW-1:0] bar_pix;
   logic          h_last;
   logic          v_last;
   logic          bar_last;

   assign h_last    = (hcnt == HW'(H_TOTAL - 1));
   assign v_last    = (vcnt == VW'(V_TOTAL - 1));
   assign bar_last  = (bar_pix == BW'(BAR_W - 1));
   assign frame_end = h_last && v_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt    <= '0;
         vcnt    <= '0;
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else begin
         if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + VW'(1);
         end else begin
            hcnt <= hcnt + HW'(1);
         end
         // bar position tracks hcnt in steps of BAR_W so no divider is needed
         if (h_last || bar_last) begin
            bar_pix <= '0;
         end else begin
            bar_pix <= bar_pix + BW'(1);
         end
         if (h_last) begin
            bar_idx <= 3'd0;
         end else if (bar_last) begin
            bar_idx <= bar_idx + 3'd1;
         end
      end
   end

   assign hsync_c = !((hcnt >= HW'(H_ACTIVE + H_FP)) &&
                      (hcnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)));
   assign vsync_c = !((vcnt >= VW'(V_ACTIVE + V_FP)) &&
                      (vcnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)));
   assign de_c       = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
   assign checker_on = hcnt[5] ^ vcnt[5];

endmodule

// File: rtl/vga_pattern_ctrl.sv
// rtl/vga_pattern_ctrl.sv - test-pattern scheduler: pattern FSM, advance requests, colour mux and output registers
module vga_pattern_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE           = DEF_H_ACTIVE,
   parameter int H_FP               = DEF_H_FP,
   parameter int H_SYNC             = DEF_H_SYNC,
   parameter int H_BP               = DEF_H_BP,
   parameter int V_ACTIVE           = DEF_V_ACTIVE,
   parameter int V_FP               = DEF_V_FP,
   parameter int V_SYNC             = DEF_V_SYNC,
   parameter int V_BP               = DEF_V_BP,
   parameter int FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       next,
   input  logic       auto_en,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic [2:0] pattern
);

   localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

   logic          hsync_c;
   logic          vsync_c;
   logic          de_c;
   logic          frame_end;
   logic          checker_on;
   logic [2:0]    bar_idx;
   pat_e          state;
   logic          pending;
   logic [FW-1:0] frame_cnt;
   logic          auto_hit;
   logic          advance;
   logic [2:0]    colour;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .hsync_c    (hsync_c),
      .vsync_c    (vsync_c),
      .de_c       (de_c),
      .frame_end  (frame_end),
      .bar_idx    (bar_idx),
      .checker_on (checker_on)
   );

   // a next pulse landing on the frame-end cycle itself is honoured directly
   assign auto_hit = auto_en && (frame_cnt == FW'(FRAMES_PER_PATTERN - 1));
   assign advance  = frame_end && (pending || next || auto_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PAT_WHITE;
         pending   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (frame_end) begin
            pending <= 1'b0;
            if (advance) begin
               state <= next_pattern(state);
            end
         end else if (next) begin
            pending <= 1'b1;
         end
         if (!auto_en || advance) begin
            frame_cnt <= '0;
         end else if (frame_end) begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   assign pattern = state;

   always_comb begin
      colour = COL_BLACK;
      case (state)
         PAT_WHITE:   colour = COL_WHITE;
         PAT_RED:     colour = COL_RED;
         PAT_GREEN:   colour = COL_GREEN;
         PAT_BLUE:    colour = COL_BLUE;
         PAT_BARS:    colour = bar_colour(bar_idx);
         PAT_CHECKER: colour = checker_on ? COL_WHITE : COL_BLACK;
         default:     colour = COL_BLACK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         r     <= 1'b0;
         g     <= 1'b0;
         b     <= 1'b0;
      end else begin
         hsync <= hsync_c;
         vsync <= vsync_c;
         de    <= de_c;
         r     <= de_c & colour[2];
         g     <= de_c & colour[1];
         b     <= de_c & colour[0];
      end
   end

endmodule

// File: doc/vga_pattern_ctrl.md
# vga_pattern_ctrl

Test-pattern controller for the VGA output path. It generates 640x480@60 sync timing from the pixel clock and schedules which 1-bit-per-channel colour source drives r/g/b. Sources are solid white, red, green, blue, 8 colour bars, checkerboard and black. Pattern changes happen only at frame boundaries, triggered by a user pulse or an automatic frame timer. It sits between the board pixel clock and the VGA connector pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- FRAMES_PER_PATTERN, 60, frames shown per pattern in auto mode; must be ≥ 1

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- next  in  1  one-cycle pulse requesting advance to the next pattern; already synchronised and debounced upstream
- auto_en  in  1  1 = advance automatically every FRAMES_PER_PATTERN frames
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  high during the visible area
- r, g, b  out  1 each  colour outputs; forced to 0 when de = 0
- pattern  out  3  index of the pattern currently displayed

## Operation
- Counters:
  - hcnt runs 0..H_TOTAL-1 (H_TOTAL = 800).
  - vcnt runs 0..V_TOTAL-1 (V_TOTAL = 525) and increments when hcnt wraps.
  - Both counters wrap to 0 together at the last pixel of the frame.
- Sync and enable:
  - hsync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
  - vsync is low for vcnt in 490..491.
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Pattern FSM states, in cycle order: WHITE(0), RED(1), GREEN(2), BLUE(3), BARS(4), CHECKER(5), BLACK(6). BLACK advances to WHITE. Index 7 is unused; if ever reached, the FSM returns to WHITE.
- Colours per state:
  - WHITE = 111, RED = 100, GREEN = 010, BLUE = 001, BLACK = 000.
  - BARS: bar index i = hcnt / (H_ACTIVE/8), kept as a bar counter with no divider. r = ~i[1], g = ~i[2], b = ~i[0], giving white, yellow, cyan, green, magenta, red, blue, black from left to right.
  - CHECKER: white when hcnt[5] ^ vcnt[5], else black (32-pixel squares).
- Advance requests:
  - A `next` pulse at any cycle sets a pending flag.
  - In auto mode, the frame counter reaching FRAMES_PER_PATTERN-1 at the frame end also sets the request.
  - The FSM advances by exactly one state at the frame end (hcnt = 799, vcnt = 524) if a request is pending. The pending flag and the frame counter then clear.
  - Several `next` pulses in one frame collapse into one advance.
  - A `next` pulse coinciding with an auto timeout gives one advance.
  - A `next` pulse in the frame-end cycle itself is taken in that same cycle.
  - The frame counter counts only while auto_en = 1; it is held at 0 while auto_en = 0.
- Reset:
  - Counters, frame counter and pending flag clear to 0; the state goes to WHITE.
  - Reset asserted mid-frame restarts timing at hcnt = vcnt = 0 on the next edge and discards any pending request.

## Timing
- Outputs are registered. hsync, vsync, de, r, g, b reflect the counter values one cycle earlier (fixed latency of 1 clk). All outputs are glitch-free.
- Reset values: hsync = 1, vsync = 1, de = 0, r = g = b = 0, pattern = 0.
- A pattern change becomes visible on the first de-high pixel of the following frame. `pattern` updates in the same cycle the counters wrap.
- Line period: 800 clk. Frame period: 420000 clk.

## Structure
- Shared package vga_pkg holds:
  - the pattern state encodings (PAT_WHITE..PAT_BLACK)
  - the default 640x480 timing constants
  - the 3-bit colour constants
- Sub-module vga_timing holds hcnt/vcnt, sync, de and a frame_end strobe.
- vga_pattern_ctrl holds the FSM, request logic, colour mux and output registers.

## Test plan
- Reset, then run one frame: hsync low exactly 96 clk per line, starting at hcnt 656; vsync low for 2 lines (1600 clk); 420000 clk between vsync falling edges; de high for 307200 clk per frame.
- auto_en = 0, single `next` pulse at vcnt = 200 → pattern changes 0→1 at the frame end; r/g/b = 100 on the next visible pixel; no further change for 3 frames.
- Three `next` pulses in one frame → pattern advances by exactly 1. Seven advances from WHITE → back to WHITE (pattern 6→0).
- auto_en = 1, FRAMES_PER_PATTERN = 2 → pattern advances every 840000 clk. A `next` pulse in the timeout frame still gives a single advance.
- BARS: pixel x = 0 → 111, x = 80 → 110, x = 400 → 100, x = 639 → 000. CHECKER at (32,0) → 111, (32,32) → 000. Blanking pixels are always 000.
- rst pulsed at vcnt = 300 with a `next` pending → outputs take their reset values one cycle later; timing restarts at 0; pattern = 0; no advance at the next frame end.
